// File: rtl/blake_host_driver_if.sv
// Host <-> BLAKE core-interface bus: control pulses and halfword data out,
// digest halfwords, acknowledge and busy back.
interface blake_host_driver_if;
    logic        bi_init;
    logic        bi_load;
    logic        bi_fetch;
    logic [15:0] bi_idata;
    logic [15:0] bi_odata;
    logic        bi_ack;
    logic        bi_busy;

    modport master (
        output bi_init, bi_load, bi_fetch, bi_idata,
        input  bi_odata, bi_ack, bi_busy
    );

    modport slave (
        input  bi_init, bi_load, bi_fetch, bi_idata,
        output bi_odata, bi_ack, bi_busy
    );
endinterface

// File: rtl/blake_host_driver.sv
// Host-side driver for the BLAKE core 16-bit load/fetch port: sends init, the
// 64-bit length, pre-padded message blocks, then reads the 256-bit digest back.
module blake_host_driver #(
    parameter int unsigned NBLK_W      = 16,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned TO_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic [63:0]         cmd_len,
    input  logic [NBLK_W-1:0]   cmd_nblocks,
    output logic                cmd_ready,
    input  logic                msg_valid,
    input  logic [31:0]         msg_data,
    output logic                msg_ready,
    output logic                dig_valid,
    output logic [255:0]        dig_data,
    output logic                err,
    blake_host_driver_if.master bi
);
    typedef enum logic [3:0] {
        IDLE, INIT, LEN_LD, LEN_ACK, LEN_IDLE, MSG_GET, MSG_LD,
        MSG_ACK, MSG_IDLE, DRAIN, F_REQ, F_ACK, F_GAP, DONE
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t            state, state_n;
    logic [63:0]       len_r, len_n;
    logic [NBLK_W-1:0] nblk_r, nblk_n;
    logic [NBLK_W-1:0] blk_cnt, blk_n;
    logic [4:0]        hw_cnt, hw_n;
    logic [3:0]        f_cnt, f_n;
    logic [TO_W-1:0]   to_cnt, to_n;
    logic [31:0]       word_r, word_n;
    logic [15:0]       idata_r, idata_n;
    logic [255:0]      dig_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_r    <= '0;
            nblk_r   <= '0;
            blk_cnt  <= '0;
            hw_cnt   <= '0;
            f_cnt    <= '0;
            to_cnt   <= '0;
            word_r   <= '0;
            idata_r  <= '0;
            dig_data <= '0;
        end else begin
            state    <= state_n;
            len_r    <= len_n;
            nblk_r   <= nblk_n;
            blk_cnt  <= blk_n;
            hw_cnt   <= hw_n;
            f_cnt    <= f_n;
            to_cnt   <= to_n;
            word_r   <= word_n;
            idata_r  <= idata_n;
            dig_data <= dig_n;
        end
    end

    assign bi.bi_idata = idata_r;

    // The outgoing halfword is registered on entry to each *_LD state so it
    // stays put through the ack wait and any msg_valid stall that follows.
    always_comb begin
        state_n     = state;
        len_n       = len_r;
        nblk_n      = nblk_r;
        blk_n       = blk_cnt;
        hw_n        = hw_cnt;
        f_n         = f_cnt;
        to_n        = to_cnt;
        word_n      = word_r;
        idata_n     = idata_r;
        dig_n       = dig_data;
        cmd_ready   = 1'b0;
        msg_ready   = 1'b0;
        dig_valid   = 1'b0;
        err         = 1'b0;
        bi.bi_init  = 1'b0;
        bi.bi_load  = 1'b0;
        bi.bi_fetch = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_start) begin
                    if (cmd_nblocks == '0) begin
                        err = 1'b1;
                    end else begin
                        len_n   = cmd_len;
                        nblk_n  = cmd_nblocks;
                        hw_n    = '0;
                        blk_n   = '0;
                        state_n = INIT;
                    end
                end
            end
            INIT: begin
                bi.bi_init = 1'b1;
                idata_n    = len_r[63:48];
                state_n    = LEN_LD;
            end
            LEN_LD, MSG_LD: begin
                bi.bi_load = 1'b1;
                to_n       = '0;
                state_n    = (state == LEN_LD) ? LEN_ACK : MSG_ACK;
            end
            LEN_ACK, MSG_ACK, F_ACK: begin
                if (bi.bi_ack) begin
                    if (state == LEN_ACK) begin
                        state_n = LEN_IDLE;
                    end else if (state == MSG_ACK) begin
                        state_n = MSG_IDLE;
                    end else begin
                        dig_n[255 - 16*int'(f_cnt) -: 16] = bi.bi_odata;
                        state_n = F_GAP;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            LEN_IDLE: begin
                if (!bi.bi_busy) begin
                    if (hw_cnt == 5'd3) begin
                        hw_n    = '0;
                        state_n = MSG_GET;
                    end else begin
                        hw_n    = hw_cnt + 5'd1;
                        idata_n = len_r[47 - 16*int'(hw_cnt[1:0]) -: 16];
                        state_n = LEN_LD;
                    end
                end
            end
            MSG_GET: begin
                if (msg_valid) begin
                    word_n    = msg_data;
                    idata_n   = msg_data[31:16];
                    msg_ready = 1'b1;
                    state_n   = MSG_LD;
                end
            end
            MSG_IDLE: begin
                if (!bi.bi_busy) begin
                    if (hw_cnt == 5'd31) begin
                        blk_n = blk_cnt + 1'b1;
                        if (blk_cnt == nblk_r - 1'b1) begin
                            state_n = DRAIN;
                        end else begin
                            hw_n    = '0;
                            state_n = MSG_GET;
                        end
                    end else begin
                        hw_n = hw_cnt + 5'd1;
                        if (!hw_cnt[0]) begin
                            idata_n = word_r[15:0];
                            state_n = MSG_LD;
                        end else begin
                            state_n = MSG_GET;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!bi.bi_busy) begin
                    f_n     = '0;
                    state_n = F_REQ;
                end
            end
            F_REQ: begin
                bi.bi_fetch = 1'b1;
                to_n        = '0;
                state_n     = F_ACK;
            end
            F_GAP: begin
                if (f_cnt == 4'd15) begin
                    state_n = DONE;
                end else begin
                    f_n     = f_cnt + 4'd1;
                    state_n = F_REQ;
                end
            end
            DONE: begin
                dig_valid = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
